// File: rtl/spi_receive_con.sv
// -----------------------------------------------------------------------------
// spi_receive_con
//   Main-FPGA end of the quad-SPI pixel link. Oversamples the incoming link
//   clock, data lines, active-low select and final-pixel strobe in the clk_in
//   domain and rebuilds DATA_WIDTH-bit pixels. The first nibble received is the
//   MSB nibble. Every pixel leaves with its raster coordinates and a one-cycle
//   valid strobe. Frame completion and framing errors are reported as strobes.
//
// Ports
//   clk_in           in   system clock (>= 6 clk_in cycles per chip_clk period)
//   rst_in           in   asynchronous, active-high reset
//   chip_clk_in      in   link clock, asynchronous to clk_in
//   chip_data_in     in   link data [LINES], changes on chip_clk falling edge
//   chip_sel_in      in   active-low transfer select
//   final_pixel_in   in   high during the last nibble of the last frame pixel
//   pixel_valid_out  out  one-cycle strobe qualifying data/hcount/vcount
//   pixel_data_out   out  reconstructed pixel [DATA_WIDTH]
//   hcount_out       out  pixel column [HCOUNT_WIDTH]
//   vcount_out       out  pixel row [VCOUNT_WIDTH]
//   frame_done_out   out  one-cycle strobe with the valid of the final pixel
//   sync_error_out   out  one-cycle strobe on a framing error
// -----------------------------------------------------------------------------
module spi_receive_con #(
  parameter int DATA_WIDTH   = 8,
  parameter int LINES        = 4,
  parameter int H_PIXELS     = 320,
  parameter int V_PIXELS     = 180,
  parameter int HCOUNT_WIDTH = 9,
  parameter int VCOUNT_WIDTH = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    chip_clk_in,
  input  logic [LINES-1:0]        chip_data_in,
  input  logic                    chip_sel_in,
  input  logic                    final_pixel_in,
  output logic                    pixel_valid_out,
  output logic [DATA_WIDTH-1:0]   pixel_data_out,
  output logic [HCOUNT_WIDTH-1:0] hcount_out,
  output logic [VCOUNT_WIDTH-1:0] vcount_out,
  output logic                    frame_done_out,
  output logic                    sync_error_out
);

  localparam int NIBBLES   = DATA_WIDTH / LINES;
  localparam int CNT_WIDTH = $clog2(NIBBLES) + 1;

  localparam logic [CNT_WIDTH-1:0]    CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]    CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]    NIB_LAST = CNT_WIDTH'(NIBBLES - 1);
  localparam logic [HCOUNT_WIDTH-1:0] H_ZERO   = {HCOUNT_WIDTH{1'b0}};
  localparam logic [HCOUNT_WIDTH-1:0] H_ONE    = HCOUNT_WIDTH'(1);
  localparam logic [HCOUNT_WIDTH-1:0] H_LAST   = HCOUNT_WIDTH'(H_PIXELS - 1);
  localparam logic [VCOUNT_WIDTH-1:0] V_ZERO   = {VCOUNT_WIDTH{1'b0}};
  localparam logic [VCOUNT_WIDTH-1:0] V_ONE    = VCOUNT_WIDTH'(1);
  localparam logic [VCOUNT_WIDTH-1:0] V_LAST   = VCOUNT_WIDTH'(V_PIXELS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  // Shift one nibble in at the LSB end; earlier nibbles move toward the MSB.
  function automatic logic [DATA_WIDTH-1:0] shift_in(
    input logic [DATA_WIDTH-1:0] cur,
    input logic [LINES-1:0]      nib
  );
    return {cur[DATA_WIDTH-LINES-1:0], nib};
  endfunction

  // True when (h, v) is the bottom-right pixel of the raster.
  function automatic logic is_last_pixel(
    input logic [HCOUNT_WIDTH-1:0] h,
    input logic [VCOUNT_WIDTH-1:0] v
  );
    return (h == H_LAST) && (v == V_LAST);
  endfunction

  // Synchronizer stages
  logic             clk_s1_r, clk_s2_r, clk_s3_r;
  logic [LINES-1:0] data_s1_r, data_s2_r;
  logic             sel_s1_r, sel_s2_r;
  logic             fin_s1_r, fin_s2_r;

  // Sampled link word, registered in the cycle the rising edge is seen
  logic             edge_s;
  logic             edge_r;
  logic [LINES-1:0] data_r;
  logic             final_r;

  // Receive state
  state_t                  state_r;
  logic [DATA_WIDTH-1:0]   shift_r;
  logic [CNT_WIDTH-1:0]    nib_cnt_r;
  logic                    emit_r;
  logic                    emit_final_r;
  logic [HCOUNT_WIDTH-1:0] hcount_r;
  logic [VCOUNT_WIDTH-1:0] vcount_r;

  // Two-flop synchronizers for every link input, plus a third flop on the clock for edge detect.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      clk_s1_r  <= 1'b0;
      clk_s2_r  <= 1'b0;
      clk_s3_r  <= 1'b0;
      data_s1_r <= {LINES{1'b0}};
      data_s2_r <= {LINES{1'b0}};
      // Select idles inactive so reset never looks like the start of a transfer.
      sel_s1_r  <= 1'b1;
      sel_s2_r  <= 1'b1;
      fin_s1_r  <= 1'b0;
      fin_s2_r  <= 1'b0;
    end else begin
      clk_s1_r  <= chip_clk_in;
      clk_s2_r  <= clk_s1_r;
      clk_s3_r  <= clk_s2_r;
      data_s1_r <= chip_data_in;
      data_s2_r <= data_s1_r;
      sel_s1_r  <= chip_sel_in;
      sel_s2_r  <= sel_s1_r;
      fin_s1_r  <= final_pixel_in;
      fin_s2_r  <= fin_s1_r;
    end
  end

  // Rising edge of the synchronized link clock.
  always_comb begin
    edge_s = clk_s2_r & ~clk_s3_r;
  end

  // Capture data and final strobe from the s2 stage in the edge cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      edge_r  <= 1'b0;
      data_r  <= {LINES{1'b0}};
      final_r <= 1'b0;
    end else begin
      edge_r <= edge_s;
      if (edge_s) begin
        data_r  <= data_s2_r;
        final_r <= fin_s2_r;
      end
    end
  end

  // Receive FSM, pixel assembly, raster counters and registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r         <= ST_IDLE;
      shift_r         <= {DATA_WIDTH{1'b0}};
      nib_cnt_r       <= CNT_ZERO;
      emit_r          <= 1'b0;
      emit_final_r    <= 1'b0;
      hcount_r        <= H_ZERO;
      vcount_r        <= V_ZERO;
      pixel_valid_out <= 1'b0;
      pixel_data_out  <= {DATA_WIDTH{1'b0}};
      hcount_out      <= H_ZERO;
      vcount_out      <= V_ZERO;
      frame_done_out  <= 1'b0;
      sync_error_out  <= 1'b0;
    end else begin
      pixel_valid_out <= 1'b0;
      frame_done_out  <= 1'b0;
      sync_error_out  <= 1'b0;
      emit_r          <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (!sel_s2_r) begin
            nib_cnt_r <= CNT_ZERO;
            state_r   <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (sel_s2_r) begin
            // Select gap: legal between pixels, an error if it cuts a pixel short.
            // Raster counters are left alone either way.
            state_r   <= ST_IDLE;
            nib_cnt_r <= CNT_ZERO;
            if (nib_cnt_r != CNT_ZERO) begin
              sync_error_out <= 1'b1;
            end
          end else if (edge_r) begin
            shift_r <= shift_in(shift_r, data_r);
            if (nib_cnt_r == NIB_LAST) begin
              // Pixel complete: count restarts now, emission happens next cycle.
              nib_cnt_r    <= CNT_ZERO;
              emit_r       <= 1'b1;
              emit_final_r <= final_r;
            end else begin
              nib_cnt_r <= nib_cnt_r + CNT_ONE;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          nib_cnt_r <= CNT_ZERO;
        end
      endcase

      if (emit_r) begin
        pixel_valid_out <= 1'b1;
        pixel_data_out  <= shift_r;
        hcount_out      <= hcount_r;
        vcount_out      <= vcount_r;
        if (emit_final_r) begin
          // Transmitter declared end of frame; resync raster to the origin.
          frame_done_out <= 1'b1;
          hcount_r       <= H_ZERO;
          vcount_r       <= V_ZERO;
          if (!is_last_pixel(hcount_r, vcount_r)) begin
            sync_error_out <= 1'b1;
          end
        end else if (hcount_r == H_LAST) begin
          hcount_r <= H_ZERO;
          vcount_r <= (vcount_r == V_LAST) ? V_ZERO : (vcount_r + V_ONE);
        end else begin
          hcount_r <= hcount_r + H_ONE;
        end
      end
    end
  end

  spi_receive_con_checker #(
    .H_PIXELS     (H_PIXELS),
    .V_PIXELS     (V_PIXELS),
    .HCOUNT_WIDTH (HCOUNT_WIDTH),
    .VCOUNT_WIDTH (VCOUNT_WIDTH)
  ) u_checker (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .pixel_valid_out (pixel_valid_out),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .frame_done_out  (frame_done_out)
  );

endmodule

// -----------------------------------------------------------------------------
// spi_receive_con_checker
//   Output protocol properties of spi_receive_con.
//
// Ports
//   clk_in, rst_in     clock and asynchronous active-high reset
//   pixel_valid_out    pixel strobe under observation
//   hcount_out         reported column
//   vcount_out         reported row
//   frame_done_out     frame strobe under observation
// -----------------------------------------------------------------------------
module spi_receive_con_checker #(
  parameter int H_PIXELS     = 320,
  parameter int V_PIXELS     = 180,
  parameter int HCOUNT_WIDTH = 9,
  parameter int VCOUNT_WIDTH = 8
) (
  input logic                    clk_in,
  input logic                    rst_in,
  input logic                    pixel_valid_out,
  input logic [HCOUNT_WIDTH-1:0] hcount_out,
  input logic [VCOUNT_WIDTH-1:0] vcount_out,
  input logic                    frame_done_out
);

  localparam logic [HCOUNT_WIDTH-1:0] H_LAST = HCOUNT_WIDTH'(H_PIXELS - 1);
  localparam logic [VCOUNT_WIDTH-1:0] V_LAST = VCOUNT_WIDTH'(V_PIXELS - 1);

  // A frame only ends on an emitted pixel.
  a_done_with_valid: assert property (@(posedge clk_in) disable iff (rst_in)
    frame_done_out |-> pixel_valid_out);

  // Pixels are at least one full link period apart, so valid is never held.
  a_valid_one_cycle: assert property (@(posedge clk_in) disable iff (rst_in)
    pixel_valid_out |=> !pixel_valid_out);

  // Reported coordinates stay inside the raster.
  a_coord_range: assert property (@(posedge clk_in) disable iff (rst_in)
    pixel_valid_out |-> ((hcount_out <= H_LAST) && (vcount_out <= V_LAST)));

endmodule

// File: tb/tb_spi_receive_con.sv
// -----------------------------------------------------------------------------
// tb_spi_receive_con
//   Self-checking bench for spi_receive_con. A reduced raster keeps a whole
//   frame short. Expected pixels come from a raster-index model: each pixel
//   advances a linear index that is split into (column, row) by division.
// -----------------------------------------------------------------------------
module tb_spi_receive_con;

  localparam int H = 112;
  localparam int V = 5;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       chip_clk_in = 1'b0;
  logic [3:0] chip_data_in = 4'h0;
  logic       chip_sel_in = 1'b1;
  logic       final_pixel_in = 1'b0;
  logic       pixel_valid_out;
  logic [7:0] pixel_data_out;
  logic [8:0] hcount_out;
  logic [7:0] vcount_out;
  logic       frame_done_out;
  logic       sync_error_out;

  spi_receive_con #(
    .H_PIXELS (H),
    .V_PIXELS (V)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .chip_clk_in     (chip_clk_in),
    .chip_data_in    (chip_data_in),
    .chip_sel_in     (chip_sel_in),
    .final_pixel_in  (final_pixel_in),
    .pixel_valid_out (pixel_valid_out),
    .pixel_data_out  (pixel_data_out),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .frame_done_out  (frame_done_out),
    .sync_error_out  (sync_error_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [8:0] h;
    logic [7:0] v;
    logic       done;
    logic       err;
    int         cyc;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  mh = 0;
  int  mv = 0;
  int  last_rise = 0;

  // Record every strobe cycle; data and coordinates only mean something with valid.
  always @(negedge clk_in) begin
    ev_t e;
    if (!rst_in && (pixel_valid_out || sync_error_out || frame_done_out)) begin
      e.valid = pixel_valid_out;
      e.data  = pixel_valid_out ? pixel_data_out : 8'h00;
      e.h     = pixel_valid_out ? hcount_out : 9'h000;
      e.v     = pixel_valid_out ? vcount_out : 8'h00;
      e.done  = frame_done_out;
      e.err   = sync_error_out;
      e.cyc   = cyc;
      obs_q.push_back(e);
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic sel_low();
    @(negedge clk_in);
    chip_sel_in = 1'b0;
    settle(2);
  endtask

  task automatic sel_high();
    @(negedge clk_in);
    chip_sel_in = 1'b1;
    settle(6);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    chip_clk_in = 1'b0;
    chip_sel_in = 1'b1;
    final_pixel_in = 1'b0;
    settle(3);
    rst_in = 1'b0;
    settle(3);
    mh = 0;
    mv = 0;
  endtask

  // One link clock period: data changes with the falling edge, lo cycles low, hi cycles high.
  task automatic send_nibble(input logic [3:0] d, input logic fin, input int lo, input int hi);
    @(negedge clk_in);
    chip_clk_in = 1'b0;
    chip_data_in = d;
    final_pixel_in = fin;
    settle(lo);
    chip_clk_in = 1'b1;
    last_rise = cyc;
    settle(hi - 1);
  endtask

  // Send a pixel and append the model's expectation for it.
  task automatic send_pixel(input logic [7:0] p, input logic fin, input int lo, input int hi);
    ev_t e;
    int idx;
    send_nibble(p[7:4], 1'b0, lo, hi);
    send_nibble(p[3:0], fin, lo, hi);
    e.valid = 1'b1;
    e.data  = p;
    e.h     = 9'(mh);
    e.v     = 8'(mv);
    e.done  = fin;
    e.err   = fin && !((mh == H - 1) && (mv == V - 1));
    e.cyc   = last_rise + 5;
    exp_q.push_back(e);
    if (fin) begin
      mh = 0;
      mv = 0;
    end else begin
      idx = mv * H + mh + 1;
      mh = idx % H;
      mv = (idx / H) % V;
    end
  endtask

  task automatic test_reset();
    settle(3);
    checks++;
    if ({pixel_valid_out, pixel_data_out, hcount_out, vcount_out, frame_done_out, sync_error_out} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {pixel_valid_out, pixel_data_out, hcount_out, vcount_out, frame_done_out, sync_error_out});
    end
    rst_in = 1'b0;
    settle(10);
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_quiet: got %0d strobes expected 0", obs_q.size());
    end
  endtask

  task automatic test_basic();
    obs_q.delete();
    exp_q.delete();
    sel_low();
    send_pixel(8'hA5, 1'b0, 3, 3);
    send_pixel(8'h3C, 1'b0, 3, 3);
    settle(8);
    sel_high();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if ({obs_q[i].valid, obs_q[i].data, obs_q[i].h, obs_q[i].v, obs_q[i].done, obs_q[i].err} !==
          {exp_q[i].valid, exp_q[i].data, exp_q[i].h, exp_q[i].v, exp_q[i].done, exp_q[i].err}) begin
        errors++;
        $display("FAIL basic_ev%0d: got d=%h h=%0d v=%0d done=%0b err=%0b expected d=%h h=%0d v=%0d done=%0b err=%0b",
                 i, obs_q[i].data, obs_q[i].h, obs_q[i].v, obs_q[i].done, obs_q[i].err,
                 exp_q[i].data, exp_q[i].h, exp_q[i].v, exp_q[i].done, exp_q[i].err);
      end
      checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL basic_latency%0d: got cycle %0d expected %0d", i, obs_q[i].cyc, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_frame();
    int done_cnt;
    int err_cnt;
    do_reset();
    obs_q.delete();
    exp_q.delete();
    sel_low();
    for (int v = 0; v < V; v++) begin
      for (int h = 0; h < H; h++) begin
        send_pixel(8'((h + v) & 255), (h == H - 1) && (v == V - 1), 3, 3);
      end
    end
    send_pixel(8'h77, 1'b0, 3, 3);
    settle(8);
    sel_high();
    checks++;
    if (obs_q.size() !== H * V + 1) begin
      errors++;
      $display("FAIL frame_count: got %0d expected %0d", obs_q.size(), H * V + 1);
    end
    done_cnt = 0;
    err_cnt = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      done_cnt += obs_q[i].done;
      err_cnt += obs_q[i].err;
      checks++;
      if ({obs_q[i].valid, obs_q[i].data, obs_q[i].h, obs_q[i].v, obs_q[i].done, obs_q[i].err} !==
          {exp_q[i].valid, exp_q[i].data, exp_q[i].h, exp_q[i].v, exp_q[i].done, exp_q[i].err}) begin
        errors++;
        $display("FAIL frame_ev%0d: got d=%h h=%0d v=%0d done=%0b err=%0b expected d=%h h=%0d v=%0d done=%0b err=%0b",
                 i, obs_q[i].data, obs_q[i].h, obs_q[i].v, obs_q[i].done, obs_q[i].err,
                 exp_q[i].data, exp_q[i].h, exp_q[i].v, exp_q[i].done, exp_q[i].err);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL frame_done_count: got %0d expected 1", done_cnt);
    end
    checks++;
    if (err_cnt !== 0) begin
      errors++;
      $display("FAIL frame_error_count: got %0d expected 0", err_cnt);
    end
  endtask

  task automatic test_early_final();
    do_reset();
    obs_q.delete();
    exp_q.delete();
    sel_low();
    for (int i = 1; i <= 100; i++) begin
      send_pixel(8'($urandom), i == 100, 3, 3);
    end
    send_pixel(8'($urandom), 1'b0, 3, 3);
    settle(8);
    sel_high();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL early_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if ({obs_q[i].valid, obs_q[i].data, obs_q[i].h, obs_q[i].v, obs_q[i].done, obs_q[i].err} !==
          {exp_q[i].valid, exp_q[i].data, exp_q[i].h, exp_q[i].v, exp_q[i].done, exp_q[i].err}) begin
        errors++;
        $display("FAIL early_ev%0d: got d=%h h=%0d v=%0d done=%0b err=%0b expected d=%h h=%0d v=%0d done=%0b err=%0b",
                 i, obs_q[i].data, obs_q[i].h, obs_q[i].v, obs_q[i].done, obs_q[i].err,
                 exp_q[i].data, exp_q[i].h, exp_q[i].v, exp_q[i].done, exp_q[i].err);
      end
    end
  endtask

  task automatic test_drop();
    ev_t e;
    obs_q.delete();
    exp_q.delete();
    sel_low();
    send_pixel(8'h5E, 1'b0, 3, 3);
    send_nibble(4'h9, 1'b0, 3, 3);
    sel_high();
    e.valid = 1'b0; e.data = 8'h00; e.h = 9'h000; e.v = 8'h00;
    e.done = 1'b0; e.err = 1'b1; e.cyc = 0;
    exp_q.push_back(e);
    sel_low();
    send_pixel(8'hC7, 1'b0, 3, 3);
    settle(8);
    sel_high();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL drop_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if ({obs_q[i].valid, obs_q[i].data, obs_q[i].h, obs_q[i].v, obs_q[i].done, obs_q[i].err} !==
          {exp_q[i].valid, exp_q[i].data, exp_q[i].h, exp_q[i].v, exp_q[i].done, exp_q[i].err}) begin
        errors++;
        $display("FAIL drop_ev%0d: got vld=%0b d=%h h=%0d v=%0d err=%0b expected vld=%0b d=%h h=%0d v=%0d err=%0b",
                 i, obs_q[i].valid, obs_q[i].data, obs_q[i].h, obs_q[i].v, obs_q[i].err,
                 exp_q[i].valid, exp_q[i].data, exp_q[i].h, exp_q[i].v, exp_q[i].err);
      end
    end
  endtask

  task automatic test_mid_reset();
    obs_q.delete();
    exp_q.delete();
    sel_low();
    send_pixel(8'h5A, 1'b0, 3, 3);
    settle(6);
    send_nibble(4'h7, 1'b0, 3, 3);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    checks++;
    if ({pixel_valid_out, pixel_data_out, hcount_out, vcount_out, frame_done_out, sync_error_out} !== 28'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h expected 0", {pixel_valid_out, pixel_data_out, hcount_out, vcount_out, frame_done_out, sync_error_out});
    end
    chip_clk_in = 1'b0;
    chip_sel_in = 1'b1;
    settle(3);
    rst_in = 1'b0;
    settle(3);
    mh = 0;
    mv = 0;
    sel_low();
    send_pixel(8'hC3, 1'b0, 3, 3);
    settle(8);
    sel_high();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL midreset_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if ({obs_q[i].valid, obs_q[i].data, obs_q[i].h, obs_q[i].v, obs_q[i].done, obs_q[i].err} !==
          {exp_q[i].valid, exp_q[i].data, exp_q[i].h, exp_q[i].v, exp_q[i].done, exp_q[i].err}) begin
        errors++;
        $display("FAIL midreset_ev%0d: got d=%h h=%0d v=%0d err=%0b expected d=%h h=%0d v=%0d err=%0b",
                 i, obs_q[i].data, obs_q[i].h, obs_q[i].v, obs_q[i].err,
                 exp_q[i].data, exp_q[i].h, exp_q[i].v, exp_q[i].err);
      end
    end
  endtask

  task automatic test_sel_high_ignored();
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      send_nibble(4'($urandom), 1'($urandom), 3, 3);
    end
    settle(10);
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL selhigh_quiet: got %0d strobes expected 0", obs_q.size());
    end
  endtask

  task automatic test_random();
    obs_q.delete();
    exp_q.delete();
    sel_low();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        sel_high();
        settle($urandom_range(0, 4));
        sel_low();
      end
      send_pixel(8'($urandom), $urandom_range(0, 15) == 0, $urandom_range(3, 5), $urandom_range(3, 5));
    end
    settle(8);
    sel_high();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if ({obs_q[i].valid, obs_q[i].data, obs_q[i].h, obs_q[i].v, obs_q[i].done, obs_q[i].err} !==
          {exp_q[i].valid, exp_q[i].data, exp_q[i].h, exp_q[i].v, exp_q[i].done, exp_q[i].err}) begin
        errors++;
        $display("FAIL random_ev%0d: got d=%h h=%0d v=%0d done=%0b err=%0b expected d=%h h=%0d v=%0d done=%0b err=%0b",
                 i, obs_q[i].data, obs_q[i].h, obs_q[i].v, obs_q[i].done, obs_q[i].err,
                 exp_q[i].data, exp_q[i].h, exp_q[i].v, exp_q[i].done, exp_q[i].err);
      end
      checks++;
      if (obs_q[i].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL random_latency%0d: got cycle %0d expected %0d", i, obs_q[i].cyc, exp_q[i].cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame();
    test_early_final();
    test_drop();
    test_mid_reset();
    test_sel_high_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
